// File: rtl/dmem_controller.sv
// dmem_controller: multi-channel data-memory arbiter between LSU consumers and memory.
// Each channel runs its own FSM (IDLE -> READ_WAIT/WRITE_WAIT -> RELAY -> IDLE).
// Same-cycle claims resolve in channel index order. Read wins over write for
// the same consumer.
// Optional macro DMEM_CTRL_ROUND_ROBIN_EN selects round-robin consumer search
// through one shared pointer. Without it, the lowest consumer index wins.
// Ports:
//   clk, reset (sync, active-low)
//   consumer_read_valid/address  -> consumer_read_ready/data   (N consumers)
//   consumer_write_valid/address/data -> consumer_write_ready
//   mem_read_valid/address  <- mem_read_ready/data             (M channels)
//   mem_write_valid/address/data <- mem_write_ready
module dmem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_e;

  state_e                          state_q [NUM_CHANNELS];
  state_e                          state_d [NUM_CHANNELS];
  logic [OW-1:0]                   owner_q [NUM_CHANNELS];
  logic [OW-1:0]                   owner_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]         mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0]        claimed_q, claimed_d;
  logic [NUM_CONSUMERS-1:0]        crr_q, crr_d, cwr_q, cwr_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
  logic [OW-1:0]                   ptr_q, ptr_d;
`endif

  logic        found;
  logic        release_ok;
  int unsigned sel, idx, own, start;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mrv_d     = mrv_q;
    mwv_d     = mwv_q;
    mra_d     = mra_q;
    mwa_d     = mwa_q;
    mwd_d     = mwd_q;
    claimed_d = claimed_q;
    crr_d     = crr_q;
    cwr_d     = cwr_q;
    crd_d     = crd_q;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    found      = 1'b0;
    release_ok = 1'b0;
    sel        = 0;
    idx        = 0;
    own        = 0;
    start      = 0;
    // Channels are walked in index order; claimed_d (and the shared pointer)
    // carry earlier channels' claims forward so later channels see them.
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      sel   = 0;
      own   = 32'(owner_q[c]);
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
      start = 32'(ptr_d);
`else
      start = 0;
`endif
      case (state_q[c])
        IDLE: begin
          for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            idx = (start + k) % NUM_CONSUMERS;
            if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])
                && !claimed_d[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          if (found) begin
            claimed_d[sel] = 1'b1;
            owner_d[c]     = OW'(sel);
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
            ptr_d = OW'((sel + 1) % NUM_CONSUMERS);
`endif
            if (consumer_read_valid[sel]) begin
              mrv_d[c] = 1'b1;
              mra_d[c*ADDR_BITS +: ADDR_BITS] = consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
              state_d[c] = READ_WAIT;
            end else begin
              mwv_d[c] = 1'b1;
              mwa_d[c*ADDR_BITS +: ADDR_BITS] = consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
              mwd_d[c*DATA_BITS +: DATA_BITS] = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
              state_d[c] = WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[c]) begin
            mrv_d[c]   = 1'b0;
            crd_d[own*DATA_BITS +: DATA_BITS] = mem_read_data[c*DATA_BITS +: DATA_BITS];
            crr_d[own] = 1'b1;
            state_d[c] = RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            mwv_d[c]   = 1'b0;
            cwr_d[own] = 1'b1;
            state_d[c] = RELAY;
          end
        end
        RELAY: begin
          // The read-ready flag tells which handshake this channel is relaying.
          release_ok = crr_q[own] ? !consumer_read_valid[own] : !consumer_write_valid[own];
          if (release_ok) begin
            crr_d[own]     = 1'b0;
            cwr_d[own]     = 1'b0;
            claimed_d[own] = 1'b0;
            state_d[c]     = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
      end
      mrv_q     <= '0;
      mwv_q     <= '0;
      mra_q     <= '0;
      mwa_q     <= '0;
      mwd_q     <= '0;
      claimed_q <= '0;
      crr_q     <= '0;
      cwr_q     <= '0;
      crd_q     <= '0;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mrv_q     <= mrv_d;
      mwv_q     <= mwv_d;
      mra_q     <= mra_d;
      mwa_q     <= mwa_d;
      mwd_q     <= mwd_d;
      claimed_q <= claimed_d;
      crr_q     <= crr_d;
      cwr_q     <= cwr_d;
      crd_q     <= crd_d;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign consumer_read_ready  = crr_q;
  assign consumer_read_data   = crd_q;
  assign consumer_write_ready = cwr_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign mem_write_valid      = mwv_q;
  assign mem_write_address    = mwa_q;
  assign mem_write_data       = mwd_q;

endmodule

// File: tb/tb_dmem_controller.sv
// tb_dmem_controller: directed bench for dmem_controller.
// Main instance uses default sizing (8 consumers, 4 channels); a second
// single-channel instance exercises arbitration fairness between two consumers.
module tb_dmem_controller;

  logic clk;
  logic reset;

  // main instance (N=8, M=4)
  logic [7:0]  c_rv, c_rr, c_wv, c_wr;
  logic [63:0] c_ra, c_rd, c_wa, c_wd;
  logic [3:0]  m_rv, m_rr, m_wv, m_wr;
  logic [31:0] m_ra, m_rd, m_wa, m_wd;

  // single-channel instance (N=8, M=1)
  logic [7:0]  c1_rv, c1_rr, c1_wv, c1_wr;
  logic [63:0] c1_ra, c1_rd, c1_wa, c1_wd;
  logic [0:0]  m1_rv, m1_rr, m1_wv, m1_wr;
  logic [7:0]  m1_ra, m1_rd, m1_wa, m1_wd;

  // memory responder
  logic       auto_mem;
  logic [3:0] a_rr, a_wr, man_rr, seen_r, seen_w;
  logic [31:0] a_rd, man_rd;
  logic [0:0] seen1;
  logic [7:0] mem [256];

  int n_checks;
  int n_pass;

  dmem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
    .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
    .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
    .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
    .mem_read_valid(m_rv), .mem_read_address(m_ra),
    .mem_read_ready(m_rr), .mem_read_data(m_rd),
    .mem_write_valid(m_wv), .mem_write_address(m_wa),
    .mem_write_data(m_wd), .mem_write_ready(m_wr)
  );

  dmem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c1_rv), .consumer_read_address(c1_ra),
    .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
    .consumer_write_valid(c1_wv), .consumer_write_address(c1_wa),
    .consumer_write_data(c1_wd), .consumer_write_ready(c1_wr),
    .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
    .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
    .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
    .mem_write_data(m1_wd), .mem_write_ready(m1_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_rr  = auto_mem ? a_rr : man_rr;
  assign m_rd  = auto_mem ? a_rd : man_rd;
  assign m_wr  = a_wr;
  assign m1_wr = 1'b0;

  // Memory answers one cycle after it first sees a valid request.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (auto_mem && m_rv[c] && seen_r[c] && !a_rr[c]) begin
        a_rr[c] = 1'b1;
        a_rd[c*8 +: 8] = mem[m_ra[c*8 +: 8]];
      end else begin
        a_rr[c] = 1'b0;
      end
      if (auto_mem && m_wv[c] && seen_w[c] && !a_wr[c]) begin
        a_wr[c] = 1'b1;
        mem[m_wa[c*8 +: 8]] = m_wd[c*8 +: 8];
      end else begin
        a_wr[c] = 1'b0;
      end
      seen_r[c] = m_rv[c];
      seen_w[c] = m_wv[c];
    end
    if (m1_rv[0] && seen1[0] && !m1_rr[0]) begin
      m1_rr[0] = 1'b1;
      m1_rd    = m1_ra ^ 8'h5A;
    end else begin
      m1_rr[0] = 1'b0;
    end
    seen1[0] = m1_rv[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got [8];
    logic [7:0] done;
    int         grants [4];
    int         exp_g  [4];
    int         ng;
    logic [1:0] raise;

    n_checks = 0; n_pass = 0;
    auto_mem = 1'b1;
    man_rr = '0; man_rd = '0;
    a_rr = '0; a_wr = '0; a_rd = '0; seen_r = '0; seen_w = '0;
    m1_rr = '0; m1_rd = '0; seen1 = '0;
    c_rv = '0; c_ra = '0; c_wv = '0; c_wa = '0; c_wd = '0;
    c1_rv = '0; c1_ra = '0; c1_wv = '0; c1_wa = '0; c1_wd = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    step(); step();

    // reset state
    check("rst_crr", 64'(c_rr), 64'h0);
    check("rst_cwr", 64'(c_wr), 64'h0);
    check("rst_mrv", 64'({m_wv, m_rv}), 64'h0);
    check("rst_addr", 64'({m_ra, m_wa}), 64'h0);
    reset = 1'b1;
    step();

    // single read: consumer 0, addr 0x05 -> 0x2A
    mem[5] = 8'h2A;
    c_rv[0] = 1'b1; c_ra[7:0] = 8'h05;
    step();
    check("rd_mrv_c1", 64'(m_rv), 64'h1);
    check("rd_addr_c1", 64'(m_ra[7:0]), 64'h05);
    check("rd_crr_c1", 64'(c_rr), 64'h0);
    step();
    check("rd_mrv_hold", 64'(m_rv), 64'h1);
    step();
    check("rd_crr_c3", 64'(c_rr), 64'h01);
    check("rd_data_c3", 64'(c_rd[7:0]), 64'h2A);
    check("rd_mrv_drop", 64'(m_rv), 64'h0);
    c_rv[0] = 1'b0;
    step();
    check("rd_crr_clr", 64'(c_rr), 64'h0);
    check("rd_data_keep", 64'(c_rd[7:0]), 64'h2A);

    // single write: consumer 2, addr 0x08, data 0x07
    c_wv[2] = 1'b1; c_wa[23:16] = 8'h08; c_wd[23:16] = 8'h07;
    step();
    check("wr_mwv", 64'(m_wv), 64'h1);
    check("wr_addr", 64'(m_wa[7:0]), 64'h08);
    check("wr_data", 64'(m_wd[7:0]), 64'h07);
    step();
    check("wr_hold", 64'({m_wv, m_wa[7:0], m_wd[7:0]}), 64'h10807);
    step();
    check("wr_cwr", 64'(c_wr), 64'h04);
    check("wr_mwv_drop", 64'(m_wv), 64'h0);
    check("wr_mem", 64'(mem[8]), 64'h07);
    c_wv[2] = 1'b0;
    step();
    check("wr_cwr_clr", 64'(c_wr), 64'h0);

    // all eight consumers read addr i, mem[i] = i+1
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(i + 1);
      c_ra[i*8 +: 8] = 8'(i);
      got[i] = 8'h00;
    end
    c_rv = 8'hFF;
    done = 8'h00;
    step();
    check("all_mrv", 64'(m_rv), 64'hF);
    check("all_maddr", 64'(m_ra), 64'h03020100);
    step(); step();
    check("all_first4", 64'(c_rr), 64'h0F);
    for (int cyc = 0; cyc < 40 && done != 8'hFF; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        if (c_rr[i] && c_rv[i]) begin
          got[i]  = c_rd[i*8 +: 8];
          done[i] = 1'b1;
          c_rv[i] = 1'b0;
        end
      end
      step();
    end
    check("all_done", 64'(done), 64'hFF);
    for (int i = 0; i < 8; i++) check($sformatf("all_data%0d", i), 64'(got[i]), 64'(i + 1));
    c_rv = '0;
    step(); step();

    // single channel, consumers 0 and 1 re-requesting continuously
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    grants = '{default: -1};
    ng = 0;
    raise = 2'b00;
    c1_ra[15:0] = 16'h1110;
    c1_rv[1:0] = 2'b11;
    for (int cyc = 0; cyc < 80 && ng < 4; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (raise[i]) begin
          c1_rv[i] = 1'b1;
          raise[i] = 1'b0;
        end else if (c1_rr[i] && c1_rv[i]) begin
          if (ng < 4) grants[ng] = i;
          ng++;
          c1_rv[i] = 1'b0;
          raise[i] = 1'b1;
        end
      end
      step();
    end
    c1_rv = '0;
    check("arb_count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("arb_grant%0d", k), 64'(grants[k]), 64'(exp_g[k]));
    step(); step(); step();

    // reset during READ_WAIT, then a late memory ready
    auto_mem = 1'b0;
    c_rv[1] = 1'b1; c_ra[15:8] = 8'h33;
    step();
    check("rst_mid_mrv", 64'(m_rv), 64'h1);
    check("rst_mid_addr", 64'(m_ra[7:0]), 64'h33);
    step();
    reset = 1'b0;
    c_rv = '0;
    step();
    check("rst_mid_outs", 64'({c_rr, c_wr, m_rv, m_wv}), 64'h0);
    check("rst_mid_addrs", 64'({m_ra, m_wa}), 64'h0);
    check("rst_mid_crd", c_rd, 64'h0);
    reset = 1'b1;
    man_rr = 4'b0001; man_rd = 32'h99;
    step();
    check("late_crr", 64'(c_rr), 64'h0);
    check("late_crd", c_rd, 64'h0);
    check("late_mrv", 64'(m_rv), 64'h0);
    man_rr = '0;
    step();
    check("late_crr2", 64'(c_rr), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
